// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CISC core front end: bus/byte widths,
// prefetch FSM state encoding and the modulo pointer helper.
package cpu_pkg;

    localparam int BYTE_W = 8;
    localparam int BUS_W  = 16;

    typedef enum logic {
        PQ_IDLE = 1'b0,
        PQ_REQ  = 1'b1
    } pq_state_e;

    // Advance a circular pointer by n (n < depth). The wrap is an explicit
    // compare-and-subtract so that non-power-of-two depths work.
    function automatic int ptr_inc(input int ptr, input int n, input int depth);
        int sum;
        sum = ptr + n;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pq_regfile.sv
// Byte storage for the prefetch queue: DEPTH x 8 registers with two write
// ports (one bus word lands in two consecutive slots) and two async reads.
module pq_regfile
    import cpu_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [PTR_W-1:0]  wa0,
    input  logic [BYTE_W-1:0] wd0,
    input  logic              we1,
    input  logic [PTR_W-1:0]  wa1,
    input  logic [BYTE_W-1:0] wd1,
    input  logic [PTR_W-1:0]  ra0,
    output logic [BYTE_W-1:0] rd0,
    input  logic [PTR_W-1:0]  ra1,
    output logic [BYTE_W-1:0] rd1
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Write both ports; callers never aim them at the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem[wa0] <= wd0;
            end
            if (we1) begin
                mem[wa1] <= wd1;
            end
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches little-endian bus words ahead of the
// decoder, buffers them as bytes in a circular queue and presents the two
// oldest bytes. Flush redirects fetching to an arbitrary (even or odd) byte.
//
// Bus handshake: fetch_req rises with fetch_addr stable and holds until a
// cycle in which fetch_ack is high; that cycle transfers fetch_data and ends
// the request. A flush withdraws any pending request; the bus never acks a
// withdrawn request.
module prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH      = 6,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            flush_addr,
    output logic                         fetch_req,
    output logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         fetch_ack,
    input  logic [BUS_W-1:0]             fetch_data,
    input  logic [1:0]                   pop,
    output logic [BYTE_W-1:0]            q_byte0,
    output logic [BYTE_W-1:0]            q_byte1,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         pop_err,
    output pq_state_e                    dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    pq_state_e         state;
    logic              skip_lo;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [CNT_W-1:0]  free_cnt;
    logic              ack_take;
    logic              pop_ok;
    logic [1:0]        push_n;
    logic [1:0]        pop_n;
    logic [BYTE_W-1:0] wd0;

    assign dbg_state = state;

    // Derive this cycle's push/pop amounts and pointer neighbours.
    always_comb begin
        free_cnt  = CNT_W'(DEPTH) - count;
        ack_take  = (state == PQ_REQ) && fetch_ack && !flush;
        pop_ok    = (pop != 2'd3) && (CNT_W'(pop) <= count);
        push_n    = 2'd0;
        if (ack_take) begin
            push_n = skip_lo ? 2'd1 : 2'd2;
        end
        pop_n     = pop_ok ? pop : 2'd0;
        rd_ptr_p1 = PTR_W'(ptr_inc(int'(rd_ptr), 1, DEPTH));
        wr_ptr_p1 = PTR_W'(ptr_inc(int'(wr_ptr), 1, DEPTH));
        wd0       = skip_lo ? fetch_data[15:8] : fetch_data[7:0];
    end

    // Fetch FSM with registered request, address and odd-start skip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PQ_IDLE;
            fetch_req  <= 1'b0;
            fetch_addr <= RESET_ADDR;
            skip_lo    <= 1'b0;
        end else if (flush) begin
            state      <= PQ_IDLE;
            fetch_req  <= 1'b0;
            fetch_addr <= {flush_addr[ADDR_W-1:1], 1'b0};
            skip_lo    <= flush_addr[0];
        end else begin
            case (state)
                PQ_IDLE: begin
                    // Space is reserved here; pops can only add to it.
                    if (free_cnt >= CNT_W'(2)) begin
                        state     <= PQ_REQ;
                        fetch_req <= 1'b1;
                    end
                end
                PQ_REQ: begin
                    if (fetch_ack) begin
                        state      <= PQ_IDLE;
                        fetch_req  <= 1'b0;
                        fetch_addr <= fetch_addr + ADDR_W'(2);
                        skip_lo    <= 1'b0;
                    end
                end
                default: begin
                    state     <= PQ_IDLE;
                    fetch_req <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers, occupancy and the illegal-pop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else begin
            pop_err <= !pop_ok;
            if (ack_take) begin
                wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), int'(push_n), DEPTH));
            end
            if (pop_ok) begin
                rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), int'(pop_n), DEPTH));
            end
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    pq_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we0   (ack_take),
        .wa0   (wr_ptr),
        .wd0   (wd0),
        .we1   (ack_take && !skip_lo),
        .wa1   (wr_ptr_p1),
        .wd1   (fetch_data[15:8]),
        .ra0   (rd_ptr),
        .rd0   (q_byte0),
        .ra1   (rd_ptr_p1),
        .rd1   (q_byte1)
    );

endmodule
